// File: rtl/nn_frame_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | nn_frame_sched                                                           |
// | Ping-pong pixel frame buffer replaying whole frames to the nn core as    |
// | gap-free bursts and returning the recognised digit on a valid/ready port.|
// | Optional: NN_SCHED_TIMEOUT_EN enables the result watchdog.               |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module nn_frame_sched #(
   parameter int FRAME_SIZE = 784,
   parameter int AW         = 10,
   parameter int MIN_GAP    = 2,
   parameter int TIMEOUT    = 2048
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [7:0]  px_data_i,
   input  logic        px_valid_i,
   input  logic        px_sof_i,
   output logic [7:0]  nn_x_o,
   output logic        nn_x_valid_o,
   output logic        nn_rst_o,
   input  logic        nn_y_valid_i,
   input  logic [3:0]  nn_N_i,
   output logic [3:0]  res_N_o,
   output logic        res_err_o,
   output logic        res_valid_o,
   input  logic        res_ready_i,
   output logic        busy_o,
   output logic [15:0] frame_cnt_o,
   output logic [15:0] drop_cnt_o
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_SIZE - 1);
   localparam int            GW        = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST  = GW'(MIN_GAP - 1);

   typedef enum logic [2:0] {
      R_IDLE   = 3'd0,
      R_PRIME  = 3'd1,
      R_STREAM = 3'd2,
      R_WAIT   = 3'd3,
      R_OUT    = 3'd4,
      R_GAP    = 3'd5
   } rd_state_t;

   rd_state_t     rd_state_q;
   logic [7:0]    mem0 [FRAME_SIZE];
   logic [7:0]    mem1 [FRAME_SIZE];
   logic [7:0]    rdata_q;

   logic [1:0]    full_q, full_d;
   logic          wr_sel_q, wr_sel_d;
   logic          wr_act_q, wr_act_d;
   logic          wr_buf_q, wr_buf_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [15:0]   drop_cnt_q, drop_cnt_d;
   logic          we, we_buf;
   logic [AW-1:0] we_addr;

   logic          rd_sel_q;
   logic [AW-1:0] rd_addr_q, beat_q;
   logic [GW-1:0] gap_q;
   logic          nn_x_valid_q, res_valid_q;
   logic [3:0]    res_N_q;
   logic [15:0]   frame_cnt_q;

   logic          release_buf, expire;
   logic [1:0]    rel_mask, free_mask;

   // A buffer released by the reader this cycle already counts as free for px_sof.
   assign release_buf = (rd_state_q == R_WAIT) && (nn_y_valid_i || expire);
   assign rel_mask    = release_buf ? (rd_sel_q ? 2'b10 : 2'b01) : 2'b00;
   assign free_mask   = ~full_q | rel_mask;

   always_comb begin
      we         = 1'b0;
      we_buf     = wr_buf_q;
      we_addr    = wr_addr_q;
      wr_act_d   = wr_act_q;
      wr_buf_d   = wr_buf_q;
      wr_addr_d  = wr_addr_q;
      wr_sel_d   = wr_sel_q;
      drop_cnt_d = drop_cnt_q;
      full_d     = full_q & ~rel_mask;
      if (px_valid_i && px_sof_i) begin
         if (wr_act_q || free_mask[wr_sel_q] || free_mask[~wr_sel_q]) begin
            we        = 1'b1;
            we_addr   = '0;
            wr_addr_d = AW'(1);
            wr_act_d  = 1'b1;
            if (wr_act_q)
               we_buf = wr_buf_q;
            else if (free_mask[wr_sel_q])
               we_buf = wr_sel_q;
            else
               we_buf = ~wr_sel_q;
            wr_buf_d = we_buf;
         end else begin
            wr_act_d = 1'b0;
            if (drop_cnt_q != 16'hFFFF)
               drop_cnt_d = drop_cnt_q + 16'd1;
         end
      end else if (px_valid_i && wr_act_q) begin
         we = 1'b1;
         if (wr_addr_q == LAST_ADDR) begin
            full_d[wr_buf_q] = 1'b1;
            wr_sel_d         = ~wr_buf_q;
            wr_act_d         = 1'b0;
         end else begin
            wr_addr_d = wr_addr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         full_q     <= 2'b00;
         wr_sel_q   <= 1'b0;
         wr_act_q   <= 1'b0;
         wr_buf_q   <= 1'b0;
         wr_addr_q  <= '0;
         drop_cnt_q <= 16'd0;
      end else begin
         full_q     <= full_d;
         wr_sel_q   <= wr_sel_d;
         wr_act_q   <= wr_act_d;
         wr_buf_q   <= wr_buf_d;
         wr_addr_q  <= wr_addr_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (we) begin
         if (we_buf)
            mem1[we_addr] <= px_data_i;
         else
            mem0[we_addr] <= px_data_i;
      end
      rdata_q <= rd_sel_q ? mem1[rd_addr_q] : mem0[rd_addr_q];
   end

`ifdef NN_SCHED_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TW-1:0] wait_cnt_q;
   logic [1:0]    abort_q;
   logic          res_err_q;

   assign expire = (rd_state_q == R_WAIT) && (wait_cnt_q == TW'(TIMEOUT - 1));

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wait_cnt_q <= '0;
         abort_q    <= 2'd0;
      end else begin
         wait_cnt_q <= (rd_state_q == R_WAIT) ? wait_cnt_q + 1'b1 : '0;
         // A result arriving on the expiry cycle wins, so no abort then.
         if (expire && !nn_y_valid_i)
            abort_q <= 2'd2;
         else if (abort_q != 2'd0)
            abort_q <= abort_q - 2'd1;
      end
   end

   assign nn_rst_o  = Rst | (abort_q != 2'd0);
   assign res_err_o = res_err_q;
`else
   assign expire    = 1'b0;
   assign nn_rst_o  = Rst;
   assign res_err_o = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         rd_state_q   <= R_IDLE;
         rd_sel_q     <= 1'b0;
         rd_addr_q    <= '0;
         beat_q       <= '0;
         gap_q        <= '0;
         nn_x_valid_q <= 1'b0;
         res_valid_q  <= 1'b0;
         res_N_q      <= 4'd0;
         frame_cnt_q  <= 16'd0;
`ifdef NN_SCHED_TIMEOUT_EN
         res_err_q    <= 1'b0;
`endif
      end else begin
         case (rd_state_q)
            R_IDLE: begin
               if (full_q[rd_sel_q]) begin
                  rd_addr_q  <= '0;
                  rd_state_q <= R_PRIME;
               end
            end
            R_PRIME: begin
               rd_addr_q    <= rd_addr_q + 1'b1;
               beat_q       <= '0;
               nn_x_valid_q <= 1'b1;
               rd_state_q   <= R_STREAM;
            end
            R_STREAM: begin
               // Address runs one beat ahead of the data and stops at the last entry.
               if (rd_addr_q != LAST_ADDR)
                  rd_addr_q <= rd_addr_q + 1'b1;
               beat_q <= beat_q + 1'b1;
               if (beat_q == LAST_ADDR) begin
                  nn_x_valid_q <= 1'b0;
                  frame_cnt_q  <= frame_cnt_q + 16'd1;
                  rd_state_q   <= R_WAIT;
               end
            end
            R_WAIT: begin
               if (release_buf) begin
                  res_N_q     <= nn_y_valid_i ? nn_N_i : 4'hF;
`ifdef NN_SCHED_TIMEOUT_EN
                  res_err_q   <= ~nn_y_valid_i;
`endif
                  res_valid_q <= 1'b1;
                  rd_sel_q    <= ~rd_sel_q;
                  rd_state_q  <= R_OUT;
               end
            end
            R_OUT: begin
               if (res_ready_i) begin
                  res_valid_q <= 1'b0;
                  gap_q       <= '0;
                  rd_state_q  <= R_GAP;
               end
            end
            R_GAP: begin
               if (gap_q == GAP_LAST)
                  rd_state_q <= R_IDLE;
               else
                  gap_q <= gap_q + 1'b1;
            end
            default: rd_state_q <= R_IDLE;
         endcase
      end
   end

   assign nn_x_o       = nn_x_valid_q ? rdata_q : 8'd0;
   assign nn_x_valid_o = nn_x_valid_q;
   assign res_N_o      = res_N_q;
   assign res_valid_o  = res_valid_q;
   assign busy_o       = (|full_q) | (rd_state_q != R_IDLE);
   assign frame_cnt_o  = frame_cnt_q;
   assign drop_cnt_o   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_nn_frame_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_nn_frame_sched                                                        |
// | Scoreboard bench: directed frames, core model, burst/result monitors.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_nn_frame_sched;

   localparam int FS      = 784;
   localparam int MIN_GAP = 2;
   localparam int TIMEOUT = 64;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic [7:0]  px_data = 8'd0;
   logic        px_valid = 1'b0;
   logic        px_sof = 1'b0;
   logic [7:0]  nn_x;
   logic        nn_x_valid;
   logic        nn_rst;
   logic        nn_y_valid;
   logic [3:0]  nn_N;
   logic [3:0]  res_N;
   logic        res_err;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic        busy;
   logic [15:0] frame_cnt;
   logic [15:0] drop_cnt;

   nn_frame_sched #(
      .FRAME_SIZE(FS),
      .AW        (10),
      .MIN_GAP   (MIN_GAP),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .px_data_i   (px_data),
      .px_valid_i  (px_valid),
      .px_sof_i    (px_sof),
      .nn_x_o      (nn_x),
      .nn_x_valid_o(nn_x_valid),
      .nn_rst_o    (nn_rst),
      .nn_y_valid_i(nn_y_valid),
      .nn_N_i      (nn_N),
      .res_N_o     (res_N),
      .res_err_o   (res_err),
      .res_valid_o (res_valid),
      .res_ready_i (res_ready),
      .busy_o      (busy),
      .frame_cnt_o (frame_cnt),
      .drop_cnt_o  (drop_cnt)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_checks = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Scoreboard queues filled by the stimulus, drained by monitors and the core model.
   int         exp_burst_q[$];
   logic [4:0] exp_res_q[$];
   logic [3:0] core_ans_q[$];

   // Test controls for the core model
   bit       core_manual = 1'b0;
   int       core_delay  = 4;
   bit       manual_fire = 1'b0;
   logic [3:0] manual_n  = 4'd0;
   int       last_px_cyc = 0;

   // Core model: answers a fixed delay after each burst unless held manual.
   bit core_prev = 1'b0;
   bit core_pending = 1'b0;
   int core_cnt = 0;
   initial begin
      nn_y_valid = 1'b0;
      nn_N       = 4'd0;
      forever begin
         @(posedge Clk);
         #2;
         nn_y_valid = 1'b0;
         if (Rst) begin
            core_prev    = 1'b0;
            core_pending = 1'b0;
         end else begin
            if (core_prev && !nn_x_valid && !core_manual) begin
               core_pending = 1'b1;
               core_cnt     = core_delay;
            end
            core_prev = nn_x_valid;
            if (manual_fire) begin
               nn_y_valid = 1'b1;
               nn_N       = manual_n;
            end else if (core_pending) begin
               if (core_cnt == 0) begin
                  nn_y_valid   = 1'b1;
                  nn_N         = (core_ans_q.size() != 0) ? core_ans_q.pop_front() : 4'd0;
                  core_pending = 1'b0;
               end else begin
                  core_cnt--;
               end
            end
         end
      end
   end

   // Burst monitor
   bit in_burst = 1'b0;
   int blen = 0, bbad = 0, bseed = 0;
   int burst_start = 0;
   int n_bursts_ended = 0;
   initial begin
      forever begin
         @(negedge Clk);
         if (Rst) begin
            in_burst = 1'b0;
         end else if (nn_x_valid) begin
            if (!in_burst) begin
               in_burst    = 1'b1;
               blen        = 0;
               bbad        = 0;
               burst_start = cyc;
               check("burst_expected", int'(exp_burst_q.size() != 0), 1);
               bseed = (exp_burst_q.size() != 0) ? exp_burst_q.pop_front() : 0;
            end
            if (nn_x != 8'((bseed + blen) & 127))
               bbad++;
            blen++;
         end else if (in_burst) begin
            check("burst_len", blen, FS);
            check("burst_data_errors", bbad, 0);
            in_burst = 1'b0;
            n_bursts_ended++;
         end
      end
   end

   // Result monitor
   bit         rv_seen = 1'b0;
   bit         unstable = 1'b0;
   logic [4:0] snap = 5'd0;
   logic [4:0] exp_r;
   initial begin
      forever begin
         @(negedge Clk);
         if (Rst) begin
            rv_seen  = 1'b0;
            unstable = 1'b0;
         end else if (res_valid) begin
            if (!rv_seen) begin
               rv_seen = 1'b1;
               snap    = {res_err, res_N};
            end else if ({res_err, res_N} != snap) begin
               unstable = 1'b1;
            end
            if (res_ready) begin
               check("res_expected", int'(exp_res_q.size() != 0), 1);
               exp_r = (exp_res_q.size() != 0) ? exp_res_q.pop_front() : 5'h1F;
               check("res_value", {res_err, res_N}, exp_r);
               check("res_stable", unstable, 0);
               rv_seen  = 1'b0;
               unstable = 1'b0;
            end
         end
      end
   end

   // Watchdog-reset pulse monitor: every nn_rst pulse outside Rst must last 2 cycles.
   int rlen = 0;
   int n_rst_pulses = 0;
   initial begin
      forever begin
         @(negedge Clk);
         if (!Rst && nn_rst) begin
            rlen++;
         end else if (rlen > 0) begin
            check("nn_rst_pulse_len", rlen, 2);
            n_rst_pulses++;
            rlen = 0;
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "global timeout");
   end

   task automatic do_reset();
      @(posedge Clk);
      #1;
      Rst      = 1'b1;
      px_valid = 1'b0;
      px_sof   = 1'b0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check("rst_nn_rst", nn_rst, 1);
      check("rst_outputs", {nn_x_valid, res_valid, busy, res_err, res_N, nn_x}, 0);
      check("rst_counters", {frame_cnt, drop_cnt}, 0);
      @(posedge Clk);
      #1;
      Rst = 1'b0;
   endtask

   task automatic send_frame(input int seed, input int npx, input bit fire);
      for (int i = 0; i < npx; i++) begin
         @(posedge Clk);
         #1;
         px_valid    = 1'b1;
         px_sof      = (i == 0);
         px_data     = 8'((seed + i) & 127);
         manual_fire = fire && (i == 0);
         last_px_cyc = cyc;
      end
   endtask

   task automatic px_idle();
      @(posedge Clk);
      #1;
      px_valid    = 1'b0;
      px_sof      = 1'b0;
      manual_fire = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      do begin
         @(negedge Clk);
         k++;
      end while (!(exp_burst_q.size() == 0 && exp_res_q.size() == 0 && !busy &&
                   !res_valid && !in_burst) && k < budget);
      check("wait_done_in_budget", int'(k < budget), 1);
   endtask

   task automatic wait_bursts(input int n, input int budget);
      int k = 0;
      while (n_bursts_ended < n && k < budget) begin
         @(negedge Clk);
         k++;
      end
      check("wait_bursts_in_budget", int'(k < budget), 1);
   endtask

   int hs_cyc;
   int base;
   int k5;

   initial begin
      // 1: single frame, N=7, latency from full to first beat
      do_reset();
      core_delay = 5;
      exp_burst_q.push_back(0);
      core_ans_q.push_back(4'd7);
      exp_res_q.push_back({1'b0, 4'd7});
      send_frame(0, FS, 1'b0);
      px_idle();
      wait_done(4000);
      check("t1_first_beat_latency", burst_start - last_px_cyc, 3);
      check("t1_frame_cnt", frame_cnt, 1);
      check("t1_drop_cnt", drop_cnt, 0);

      // 2: three back-to-back frames while core is stalled -> third dropped
      do_reset();
      core_delay = 20;
      exp_burst_q.push_back(1);
      exp_burst_q.push_back(2);
      core_ans_q.push_back(4'd1);
      core_ans_q.push_back(4'd2);
      exp_res_q.push_back({1'b0, 4'd1});
      exp_res_q.push_back({1'b0, 4'd2});
      send_frame(1, FS, 1'b0);
      send_frame(2, FS, 1'b0);
      send_frame(3, FS, 1'b0);
      px_idle();
      wait_done(6000);
      check("t2_drop_cnt", drop_cnt, 1);
      check("t2_frame_cnt", frame_cnt, 2);

      // 3: px_sof in the cycle the reader releases the last full buffer
      do_reset();
      core_manual = 1'b1;
      core_delay  = 4;
      exp_burst_q.push_back(80);
      exp_burst_q.push_back(90);
      exp_burst_q.push_back(100);
      core_ans_q.push_back(4'd11);
      core_ans_q.push_back(4'd12);
      exp_res_q.push_back({1'b0, 4'd3});
      exp_res_q.push_back({1'b0, 4'd11});
      exp_res_q.push_back({1'b0, 4'd12});
      base = n_bursts_ended;
      send_frame(80, FS, 1'b0);
      send_frame(90, FS, 1'b0);
      px_idle();
      wait_bursts(base + 1, 4000);
      core_manual = 1'b0;
      manual_n    = 4'd3;
      repeat (3) @(posedge Clk);
      send_frame(100, FS, 1'b1);
      px_idle();
      wait_done(6000);
      check("t3_drop_cnt", drop_cnt, 0);
      check("t3_frame_cnt", frame_cnt, 3);

      // 4: stray pixels, restart at pixel 300, then a full frame
      do_reset();
      core_delay = 2;
      exp_burst_q.push_back(50);
      core_ans_q.push_back(4'd4);
      exp_res_q.push_back({1'b0, 4'd4});
      repeat (5) begin
         @(posedge Clk);
         #1;
         px_valid = 1'b1;
         px_sof   = 1'b0;
         px_data  = 8'h55;
      end
      send_frame(10, 300, 1'b0);
      send_frame(50, FS, 1'b0);
      px_idle();
      wait_done(4000);
      check("t4_frame_cnt", frame_cnt, 1);
      check("t4_drop_cnt", drop_cnt, 0);

      // 5: result held 50 cycles; next burst only after handshake + MIN_GAP
      do_reset();
      res_ready  = 1'b0;
      core_delay = 3;
      exp_burst_q.push_back(20);
      exp_burst_q.push_back(30);
      core_ans_q.push_back(4'd5);
      core_ans_q.push_back(4'd6);
      exp_res_q.push_back({1'b0, 4'd5});
      exp_res_q.push_back({1'b0, 4'd6});
      send_frame(20, FS, 1'b0);
      send_frame(30, FS, 1'b0);
      px_idle();
      k5 = 0;
      while (!res_valid && k5 < 4000) begin
         @(negedge Clk);
         k5++;
      end
      check("t5_res_valid_seen", int'(k5 < 4000), 1);
      repeat (50) @(negedge Clk);
      check("t5_res_valid_held", res_valid, 1);
      check("t5_no_burst_while_held", nn_x_valid, 0);
      @(posedge Clk);
      #1;
      res_ready = 1'b1;
      hs_cyc    = cyc;
      wait_done(4000);
      check("t5_gap_to_next_burst", burst_start - hs_cyc, MIN_GAP + 3);

`ifdef NN_SCHED_TIMEOUT_EN
      // 6: core never answers the first frame -> watchdog abort
      do_reset();
      core_manual = 1'b1;
      core_delay  = 3;
      exp_burst_q.push_back(60);
      exp_burst_q.push_back(70);
      core_ans_q.push_back(4'd9);
      exp_res_q.push_back({1'b1, 4'hF});
      exp_res_q.push_back({1'b0, 4'd9});
      base = n_bursts_ended;
      k5   = n_rst_pulses;
      send_frame(60, FS, 1'b0);
      send_frame(70, FS, 1'b0);
      px_idle();
      wait_bursts(base + 1, 4000);
      core_manual = 1'b0;
      wait_done(4000);
      check("t6_rst_pulses", n_rst_pulses - k5, 1);
      check("t6_frame_cnt", frame_cnt, 2);
`endif

      repeat (5) @(negedge Clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
